// File: rtl/adv7513_reconf_sequencer.sv
// adv7513_reconf_sequencer: turns reconf pulses and latched video settings into an
// ordered ADV7513 register-write burst over a single-outstanding I2C request/ack handshake.
module adv7513_reconf_sequencer #(
   parameter int unsigned SETTLE_CYCLES = 1024,
   parameter int unsigned MAX_RETRY     = 3,
   parameter logic [7:0]  DEV_ADDR      = 8'h72
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       reconf_in,
   input  logic       hpd,
   input  logic [7:0] clock_delay,
   input  logic [1:0] colorspace,
   input  logic [5:0] vic,
   input  logic [1:0] pixel_repeat,
   output logic       i2c_req,
   output logic [7:0] i2c_dev,
   output logic [7:0] i2c_reg,
   output logic [7:0] i2c_data,
   input  logic       i2c_ack,
   input  logic       i2c_err,
   output logic       busy,
   output logic       done,
   output logic       error
);
   localparam int CW = $clog2(SETTLE_CYCLES + 1);
   localparam int RW = $clog2(MAX_RETRY + 2);
   localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
   localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

   typedef enum logic [2:0] {IDLE, SETTLE, LATCH, ISSUE, WAIT, FINISH} state_t;

   state_t        state_q;
   logic          pending_q, lost_q, req_q, busy_q, done_q, error_q;
   logic [CW-1:0] cnt_q;
   logic [RW-1:0] retry_q;
   logic [2:0]    idx_q;
   logic [7:0]    reg_q, data_q, cdly_q;
   logic [1:0]    cs_q, prep_q;
   logic [5:0]    vic_q;
   logic [7:0]    reg_d, data_d;
   logic          ycc;

   assign ycc      = cs_q == 2'd1;
   assign i2c_dev  = DEV_ADDR;
   assign i2c_req  = req_q;
   assign i2c_reg  = reg_q;
   assign i2c_data = data_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign error    = error_q;

   // Write table, driven only from the shadow copies taken in LATCH
   always_comb begin
      reg_d = 8'h41;
      data_d = 8'h10;
      case (idx_q)
         3'd1: begin reg_d = 8'hBA; data_d = cdly_q; end
         3'd2: begin reg_d = 8'h16; data_d = ycc ? 8'hB5 : 8'h30; end
         3'd3: begin reg_d = 8'h18; data_d = ycc ? 8'hAC : 8'h46; end
         3'd4: begin reg_d = 8'h3B; data_d = 8'h60 | {3'b000, prep_q, 3'b000}; end
         3'd5: begin reg_d = 8'h3C; data_d = {2'b00, vic_q}; end
         default: ;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= IDLE;
         pending_q <= 1'b1;
         lost_q    <= 1'b0;
         req_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
         cnt_q     <= '0;
         retry_q   <= '0;
         idx_q     <= '0;
         reg_q     <= '0;
         data_q    <= '0;
         cdly_q    <= '0;
         cs_q      <= '0;
         prep_q    <= '0;
         vic_q     <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (pending_q && hpd) begin
                  state_q <= SETTLE;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
               end
            end
            SETTLE: begin
               if (!hpd) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else if (reconf_in) begin
                  cnt_q <= '0;
               end else if (cnt_q == SETTLE_LAST) begin
                  state_q   <= LATCH;
                  pending_q <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            LATCH: begin
               cdly_q  <= clock_delay;
               cs_q    <= colorspace;
               prep_q  <= pixel_repeat;
               vic_q   <= vic;
               idx_q   <= '0;
               retry_q <= '0;
               lost_q  <= 1'b0;
               state_q <= ISSUE;
            end
            ISSUE: begin
               reg_q   <= reg_d;
               data_q  <= data_d;
               req_q   <= 1'b1;
               state_q <= WAIT;
               if (!hpd) lost_q <= 1'b1;
            end
            WAIT: begin
               if (!hpd) lost_q <= 1'b1;
               if (i2c_ack || i2c_err) begin
                  req_q <= 1'b0;
                  // A lost hot-plug ends the pass after the in-flight write, success or not
                  if (lost_q || !hpd) begin
                     state_q   <= IDLE;
                     busy_q    <= 1'b0;
                     pending_q <= 1'b1;
                     retry_q   <= '0;
                  end else if (i2c_err) begin
                     if (retry_q < RETRY_MAX) begin
                        retry_q <= retry_q + 1'b1;
                        state_q <= ISSUE;
                     end else begin
                        error_q <= 1'b1;
                        retry_q <= '0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                     end
                  end else begin
                     retry_q <= '0;
                     if (idx_q == 3'd5) begin
                        done_q  <= 1'b1;
                        error_q <= 1'b0;
                        state_q <= FINISH;
                     end else begin
                        idx_q   <= idx_q + 1'b1;
                        state_q <= ISSUE;
                     end
                  end
               end
            end
            FINISH: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
         if (reconf_in) pending_q <= 1'b1;
      end
   end
endmodule

// File: tb/tb_adv7513_reconf_sequencer.sv
// tb_adv7513_reconf_sequencer: directed vectors and corner-case sequences for the
// ADV7513 write sequencer, with a bench-side I2C responder that logs every request.
module tb_adv7513_reconf_sequencer;
   localparam int SETTLE = 16;
   // SETTLE quiet cycles counted from 0, then LATCH and ISSUE before req is visible
   localparam int START_LAT = SETTLE + 3;

   typedef struct {
      logic [7:0]  cd;
      logic [1:0]  cs;
      logic [5:0]  v;
      logic [1:0]  pr;
      logic [47:0] exp;
   } vec_t;

   logic       clock = 1'b0, reset = 1'b1, reconf_in = 1'b0, hpd = 1'b0;
   logic [7:0] clock_delay = '0;
   logic [1:0] colorspace = '0, pixel_repeat = '0;
   logic [5:0] vic = '0;
   logic       i2c_req, busy, done, error;
   logic [7:0] i2c_dev, i2c_reg, i2c_data;
   logic       i2c_ack = 1'b0, i2c_err = 1'b0;

   int checks = 0, failures = 0;
   int cyc = 0, nreq = 0, done_cnt = 0, age = 0, lat = 3;
   int ack_cyc = 0, done_cyc = 0, err_total = 0, err_limit = 0;
   logic [7:0] err_reg = '0;
   logic       prev_req = 1'b0;
   logic [7:0] log_reg [256];
   logic [7:0] log_data [256];
   int         log_cyc [256];
   vec_t       vecs [4];

   adv7513_reconf_sequencer #(.SETTLE_CYCLES(SETTLE), .MAX_RETRY(3), .DEV_ADDR(8'h72)) dut (
      .clock(clock), .reset(reset), .reconf_in(reconf_in), .hpd(hpd),
      .clock_delay(clock_delay), .colorspace(colorspace), .vic(vic), .pixel_repeat(pixel_repeat),
      .i2c_req(i2c_req), .i2c_dev(i2c_dev), .i2c_reg(i2c_reg), .i2c_data(i2c_data),
      .i2c_ack(i2c_ack), .i2c_err(i2c_err), .busy(busy), .done(done), .error(error)
   );

   always #5 clock = ~clock;

   // I2C master model: logs each new request, answers after lat cycles, injects NACKs on demand
   initial begin
      forever begin
         @(negedge clock);
         cyc++;
         i2c_ack = 1'b0;
         i2c_err = 1'b0;
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (i2c_req && !prev_req) begin
            if (nreq < 256) begin
               log_reg[nreq] = i2c_reg;
               log_data[nreq] = i2c_data;
               log_cyc[nreq] = cyc;
            end
            nreq++;
            age = 0;
         end else if (i2c_req) begin
            age++;
         end
         if (i2c_req && age == lat - 1) begin
            ack_cyc = cyc;
            if (i2c_reg == err_reg && err_total < err_limit) begin
               i2c_err = 1'b1;
               err_total++;
            end else begin
               i2c_ack = 1'b1;
            end
         end
         prev_req = i2c_req;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic pulse();
      reconf_in = 1'b1;
      @(negedge clock);
      reconf_in = 1'b0;
   endtask

   task automatic set_in(input logic [7:0] cd, input logic [1:0] cs, input logic [5:0] v, input logic [1:0] pr);
      clock_delay = cd;
      colorspace = cs;
      vic = v;
      pixel_repeat = pr;
   endtask

   // kind 0: done count reaches target, 1: request count reaches target, 2: error set
   task automatic wait_for(input int kind, input int target, input string name);
      int n;
      n = 0;
      while (!((kind == 0 && done_cnt >= target) || (kind == 1 && nreq >= target) || (kind == 2 && error)) && n < 2000) begin
         @(negedge clock);
         n++;
      end
      if (n >= 2000) begin
         checks++;
         failures++;
         $display("FAIL %s: timed out, kind %0d target %0d not reached", name, kind, target);
      end
   endtask

   task automatic check_pass(input string tag, input int base, input logic [47:0] exp);
      logic [47:0] regs;
      regs = 48'h41BA_1618_3B3C;
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("%s reg%0d", tag, i), log_reg[base+i], regs[47-8*i -: 8]);
         chk($sformatf("%s data%0d", tag, i), log_data[base+i], exp[47-8*i -: 8]);
      end
   endtask

   initial begin
      int base, d0, c;
      vecs[0] = '{8'h80, 2'd1, 6'd16, 2'd1, 48'h10_80_B5_AC_68_10};
      vecs[1] = '{8'h3C, 2'd2, 6'd63, 2'd3, 48'h10_3C_30_46_78_3F};
      vecs[2] = '{8'hFF, 2'd3, 6'd1,  2'd2, 48'h10_FF_30_46_70_01};
      vecs[3] = '{8'h00, 2'd0, 6'd42, 2'd0, 48'h10_00_30_46_60_2A};

      set_in(8'h55, 2'd0, 6'd4, 2'd0);
      cycles(3);
      chk("reset req", i2c_req, 0);
      chk("reset reg", i2c_reg, 0);
      chk("reset data", i2c_data, 0);
      chk("reset busy", busy, 0);
      chk("reset done", done, 0);
      chk("reset error", error, 0);
      chk("dev addr", i2c_dev, 8'h72);

      // hpd low out of reset: nothing happens until hot-plug
      reset = 1'b0;
      cycles(40);
      chk("hpd low no req", nreq, 0);
      chk("hpd low idle", busy, 0);
      hpd = 1'b1;
      c = 0;
      while (!i2c_req && c < 200) begin
         @(negedge clock);
         c++;
      end
      chk("hpd rise to first req", c, START_LAT);
      wait_for(0, 1, "first pass done");
      cycles(5);
      check_pass("basic", 0, 48'h10_55_30_46_60_04);
      chk("basic count", nreq, 6);
      chk("basic done once", done_cnt, 1);
      chk("basic busy low", busy, 0);
      chk("ack to next req", log_cyc[1] - log_cyc[0], lat + 1);
      chk("final ack to done", done_cyc - ack_cyc, 1);

      for (int v = 0; v < 4; v++) begin
         base = nreq;
         d0 = done_cnt;
         set_in(vecs[v].cd, vecs[v].cs, vecs[v].v, vecs[v].pr);
         pulse();
         wait_for(0, d0 + 1, $sformatf("vec%0d done", v));
         cycles(5);
         check_pass($sformatf("vec%0d", v), base, vecs[v].exp);
         chk($sformatf("vec%0d count", v), nreq - base, 6);
         chk($sformatf("vec%0d error", v), error, 0);
      end

      // Burst of reconf pulses during SETTLE coalesces into one pass
      base = nreq;
      d0 = done_cnt;
      set_in(8'h21, 2'd0, 6'd3, 2'd0);
      pulse();
      cycles(5);
      pulse();
      cycles(4);
      pulse();
      c = 0;
      while (!i2c_req && c < 200) begin
         @(negedge clock);
         c++;
      end
      chk("coalesce latency", c, START_LAT - 1);
      wait_for(0, d0 + 1, "coalesce done");
      cycles(60);
      chk("coalesce single pass", nreq - base, 6);
      chk("coalesce done count", done_cnt, d0 + 1);
      check_pass("coalesce", base, 48'h10_21_30_46_60_03);

      // Settings change and reconf mid-burst: old shadow values finish, then a new pass
      base = nreq;
      d0 = done_cnt;
      set_in(8'h11, 2'd0, 6'd5, 2'd0);
      pulse();
      wait_for(1, base + 4, "mid reach idx3");
      set_in(8'h22, 2'd1, 6'd7, 2'd2);
      pulse();
      wait_for(0, d0 + 2, "mid two passes");
      cycles(5);
      check_pass("mid old", base, 48'h10_11_30_46_60_05);
      check_pass("mid new", base + 6, 48'h10_22_B5_AC_70_07);
      chk("mid count", nreq - base, 12);

      // Four NACKs on 0x16 exhaust the retries
      base = nreq;
      d0 = done_cnt;
      err_reg = 8'h16;
      err_limit = err_total + 4;
      set_in(8'h33, 2'd0, 6'd2, 2'd0);
      pulse();
      wait_for(2, 0, "abort error");
      cycles(40);
      chk("abort count", nreq - base, 6);
      for (int i = 2; i < 6; i++) chk($sformatf("abort attempt%0d reg", i - 1), log_reg[base+i], 8'h16);
      chk("abort error set", error, 1);
      chk("abort no done", done_cnt, d0);
      chk("abort busy low", busy, 0);
      base = nreq;
      pulse();
      wait_for(0, d0 + 1, "recover done");
      cycles(5);
      chk("recover error clear", error, 0);
      check_pass("recover", base, 48'h10_33_30_46_60_02);

      // hpd drops while a write is outstanding
      lat = 8;
      base = nreq;
      d0 = done_cnt;
      pulse();
      wait_for(1, base + 2, "hpd drop reach idx1");
      hpd = 1'b0;
      cycles(3);
      chk("hpd drop write held", i2c_req, 1);
      cycles(60);
      chk("hpd drop no more req", nreq - base, 2);
      chk("hpd drop idle", busy, 0);
      chk("hpd drop no done", done_cnt, d0);
      chk("hpd drop no error", error, 0);
      hpd = 1'b1;
      wait_for(0, d0 + 1, "hpd resume done");
      cycles(5);
      chk("hpd resume count", nreq - base, 8);
      check_pass("hpd resume", base + 2, 48'h10_33_30_46_60_02);

      // Reset while a request is outstanding
      lat = 3;
      base = nreq;
      d0 = done_cnt;
      pulse();
      wait_for(1, base + 1, "reset mid req");
      reset = 1'b1;
      cycles(1);
      chk("reset mid req drop", i2c_req, 0);
      chk("reset mid busy", busy, 0);
      cycles(2);
      reset = 1'b0;
      wait_for(0, d0 + 1, "post reset pass");
      cycles(5);
      chk("post reset count", nreq - base, 7);
      chk("post reset error", error, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
